// File: rtl/aes_round_ctrl.sv
// AES-128 iterative round scheduler: whitening on accept, one external round per cycle,
// final state held on text_o until the consumer takes it.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text_i,
  input  logic [127:0] key_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_o,
  output logic [127:0] dp_state_o,
  output logic [127:0] dp_key_o,
  output logic         dp_final_o,
  output logic [3:0]   dp_round_o,
  input  logic [127:0] dp_result_i,
  output logic [127:0] ks_key_o,
  output logic [7:0]   ks_rcon_o,
  input  logic [127:0] ks_next_i
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] text_q, text_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  assign last_round = (round_q == 4'(NR));

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    text_d  = text_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        state_d = text_i ^ key_i;
        key_d   = key_i;
        round_d = 4'd1;
        rcon_d  = 8'h01;
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = dp_result_i;
        key_d   = ks_next_i;
        rcon_d  = xtime(rcon_q);
        round_d = round_q + 4'd1;
        if (last_round) begin
          text_d  = dp_result_i;
          round_d = 4'd0;
          fsm_d   = DONE;
        end
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      text_q  <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      text_q  <= text_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // Everything handed to the datapath comes from registers; only dp_key_o is a passthrough.
  assign in_ready   = (fsm_q == IDLE);
  assign out_valid  = (fsm_q == DONE);
  assign text_o     = text_q;
  assign dp_state_o = state_q;
  assign ks_key_o   = key_q;
  assign ks_rcon_o  = rcon_q;
  assign dp_key_o   = ks_next_i;
  assign dp_round_o = (fsm_q == ROUND) ? round_q : 4'd0;
  assign dp_final_o = (fsm_q == ROUND) && last_round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: XOR toy datapath, real AES round model, NR=1 build.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NR=10 instance
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, dp_final;
  logic [127:0] text_i = '0, key_i = '0;
  logic [127:0] text_o, dp_state, dp_key, dp_result, ks_key, ks_next;
  logic [3:0]   dp_round;
  logic [7:0]   ks_rcon;
  logic         aes_mode = 1'b0;

  // NR=1 instance
  logic         in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic         in_ready1, out_valid1, dp_final1;
  logic [127:0] text_o1, dp_state1, dp_key1, dp_result1, ks_key1, ks_next1;
  logic [3:0]   dp_round1;
  logic [7:0]   ks_rcon1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  logic [127:0] res_q[$];

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .text_i(text_i), .key_i(key_i), .out_valid(out_valid), .out_ready(out_ready),
    .text_o(text_o), .dp_state_o(dp_state), .dp_key_o(dp_key), .dp_final_o(dp_final),
    .dp_round_o(dp_round), .dp_result_i(dp_result), .ks_key_o(ks_key),
    .ks_rcon_o(ks_rcon), .ks_next_i(ks_next)
  );

  aes_round_ctrl #(.NR(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .text_i(128'h0), .key_i(128'h0), .out_valid(out_valid1), .out_ready(out_ready1),
    .text_o(text_o1), .dp_state_o(dp_state1), .dp_key_o(dp_key1), .dp_final_o(dp_final1),
    .dp_round_o(dp_round1), .dp_result_i(dp_result1), .ks_key_o(ks_key1),
    .ks_rcon_o(ks_rcon1), .ks_next_i(ks_next1)
  );

  // GF(2^8) helpers for the AES round model
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'hFE;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k,
                                           input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
    if (!fin)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3 = k[31:0];
    logic [31:0] t, w0, w1, w2;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    return {w0, w1, w2, w3 ^ w2};
  endfunction

  always_comb begin
    if (aes_mode) ks_next = kexp(ks_key, ks_rcon);
    else          ks_next = ks_key ^ {120'b0, ks_rcon};
  end

  always_comb begin
    if (aes_mode) dp_result = aes_rnd(dp_state, dp_key, dp_final);
    else          dp_result = dp_state ^ dp_key;
  end

  assign ks_next1   = ks_key1 ^ {120'b0, ks_rcon1};
  assign dp_result1 = dp_state1 ^ dp_key1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    if (!rst && out_valid && out_ready) res_q.push_back(text_o);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [127:0] t, input logic [127:0] k, output logic [127:0] res);
    int n = 0;
    text_i = t; key_i = k; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 30) begin step(); n++; end
    chk("job_timeout", 128'(out_valid), 128'd1);
    res = text_o;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  initial begin
    logic [127:0] res;
    logic         saw_valid;
    int           n;

    // reset then idle
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_text_o", text_o, 128'h0);
    chk("rst_round", 128'(dp_round), 128'd0);
    chk("rst_rcon", 128'(ks_rcon), 128'h01);

    // XOR model, rcon sequence and final-round flag
    text_i = '0; key_i = '0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("acc_in_ready", 128'(in_ready), 128'd0);
    for (int r = 1; r <= 10; r++) begin
      chk($sformatf("round_%0d", r), 128'(dp_round), 128'(r));
      chk($sformatf("rcon_%0d", r), 128'(ks_rcon), 128'(rcon_tbl[r-1]));
      chk($sformatf("final_%0d", r), 128'(dp_final), 128'(r == 10));
      chk($sformatf("ov_early_%0d", r), 128'(out_valid), 128'd0);
      step();
    end
    chk("done_valid", 128'(out_valid), 128'd1);
    chk("done_text", text_o, 128'h9C);
    chk("done_round", 128'(dp_round), 128'd0);

    // hold under backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_text", text_o, 128'h9C);
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_valid", 128'(out_valid), 128'd0);
    chk("release_in_ready", 128'(in_ready), 128'd1);

    // back-to-back with in_valid held high; late text_i change must not leak in
    acc_q.delete(); res_q.delete();
    out_ready = 1'b1; text_i = '0; key_i = '0; in_valid = 1'b1;
    step();
    text_i = 128'h55;
    n = 0;
    while (acc_q.size() < 3 && n < 60) begin step(); n++; end
    in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 3 && n < 30) begin step(); n++; end
    out_ready = 1'b0;
    chk("b2b_acc_cnt", 128'(acc_q.size()), 128'd3);
    chk("b2b_res_cnt", 128'(res_q.size()), 128'd3);
    if (acc_q.size() == 3 && res_q.size() == 3) begin
      chk("b2b_gap1", 128'(acc_q[1] - acc_q[0]), 128'd12);
      chk("b2b_gap2", 128'(acc_q[2] - acc_q[1]), 128'd12);
      chk("b2b_res0", res_q[0], 128'h9C);
      chk("b2b_res1", res_q[1], 128'hC9);
    end

    // reset in the middle of round 5
    text_i = '0; key_i = '0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (dp_round != 4'd5 && n < 20) begin step(); n++; end
    chk("abort_reach_r5", 128'(dp_round), 128'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_round", 128'(dp_round), 128'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw_valid |= out_valid;
      step();
    end
    chk("abort_no_valid", 128'(saw_valid), 128'd0);
    run_job(128'h1234, 128'hF0, res);
    chk("after_abort", res, 128'h1258);

    // real AES round model, FIPS-197 vectors
    aes_mode = 1'b1;
    run_job(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, res);
    chk("fips_c1", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_job(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, res);
    chk("fips_b", res, 128'h3925841d02dc09fbdc118597196a0b32);
    aes_mode = 1'b0;

    // NR=1 build
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("nr1_final", 128'(dp_final1), 128'd1);
    chk("nr1_round", 128'(dp_round1), 128'd1);
    chk("nr1_ov_early", 128'(out_valid1), 128'd0);
    step();
    chk("nr1_valid", 128'(out_valid1), 128'd1);
    chk("nr1_text", text_o1, 128'h01);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("nr1_in_ready", 128'(in_ready1), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
